// File: rtl/lzc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lzc_pkg : scan-direction constants and count-width helper for lzc_counter   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lzc_pkg;

  localparam int unsigned LZC_TRAILING = 0;
  localparam int unsigned LZC_LEADING  = 1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lzc_node.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lzc_node : merges two child (valid, index) pairs of the scan tree          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lzc_node #(
  parameter int unsigned IDX_WIDTH = 1,
  parameter int unsigned LEVEL     = 0
) (
  input  logic                 i_lo_vld,
  input  logic [IDX_WIDTH-1:0] i_lo_idx,
  input  logic                 i_hi_vld,
  input  logic [IDX_WIDTH-1:0] i_hi_idx,
  output logic                 o_vld,
  output logic [IDX_WIDTH-1:0] o_idx
);

  assign o_vld = i_lo_vld | i_hi_vld;

  // The lower child sits nearer the scan start, so it wins; an empty subtree yields index 0.
  always_comb begin
    o_idx = i_lo_idx;
    if (!i_lo_vld) begin
      o_idx        = i_hi_idx;
      o_idx[LEVEL] = i_hi_vld;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lzc_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lzc_counter : leading/trailing zero counter built as a balanced tree        |
// | Define LZC_OUT_REG_EN to register cnt_o/empty_o (1 cycle latency).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lzc_counter
  import lzc_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MODE  = 0,
  localparam int unsigned CNT_WIDTH = cnt_width(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int unsigned c_leaves = 1 << CNT_WIDTH;
  localparam int unsigned c_nodes  = 2 * c_leaves - 1;

  if (WIDTH == 0 || MODE > 1) begin : g_param_check
    $fatal(1, "lzc_counter: illegal WIDTH=%0d or MODE=%0d", WIDTH, MODE);
  end

  // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves start at c_leaves-1.
  logic [c_nodes-1:0]   w_vld;
  logic [CNT_WIDTH-1:0] w_idx [c_nodes];
  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 w_empty;

  // Leading mode reverses the input so both modes count from leaf 0; padding lands on the far end.
  for (genvar i = 0; i < c_leaves; i++) begin : g_leaf
    if (i < WIDTH) begin : g_bit
      if (MODE == LZC_LEADING) begin : g_lead
        assign w_vld[c_leaves-1+i] = in_i[WIDTH-1-i];
      end else begin : g_trail
        assign w_vld[c_leaves-1+i] = in_i[i];
      end
    end else begin : g_pad
      assign w_vld[c_leaves-1+i] = 1'b0;
    end
    assign w_idx[c_leaves-1+i] = '0;
  end

  for (genvar l = 0; l < CNT_WIDTH; l++) begin : g_level
    for (genvar k = 0; k < (c_leaves >> (l + 1)); k++) begin : g_node
      localparam int unsigned c_n = (1 << (CNT_WIDTH - 1 - l)) - 1 + k;
      lzc_node #(
        .IDX_WIDTH (CNT_WIDTH),
        .LEVEL     (l)
      ) u_node (
        .i_lo_vld (w_vld[2*c_n+1]),
        .i_lo_idx (w_idx[2*c_n+1]),
        .i_hi_vld (w_vld[2*c_n+2]),
        .i_hi_idx (w_idx[2*c_n+2]),
        .o_vld    (w_vld[c_n]),
        .o_idx    (w_idx[c_n])
      );
    end
  end

  assign w_cnt   = w_idx[0];
  assign w_empty = ~w_vld[0];

`ifdef LZC_OUT_REG_EN
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_empty <= 1'b1;
    end else begin
      r_cnt   <= w_cnt;
      r_empty <= w_empty;
    end
  end

  assign cnt_o   = r_cnt;
  assign empty_o = r_empty;
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk_i ^ rst_ni;

  assign cnt_o   = w_cnt;
  assign empty_o = w_empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lzc_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lzc_counter : scoreboard bench for lzc_counter across widths and modes   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lzc_counter;

`ifdef LZC_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int             cyc;
    logic [4:0][7:0] cnt;
    logic [4:0]      emp;
  } exp_t;

  logic       clk;
  logic       rst_ni;
  logic [7:0] in8;
  logic [4:0] in5;
  logic [0:0] in1;

  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [0:0] cnt_e;
  logic       emp_a, emp_b, emp_c, emp_d, emp_e;

  logic [4:0][7:0] act_cnt;
  logic [4:0]      act_emp;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  string names [5] = '{"w8_trail", "w8_lead", "w5_trail", "w5_lead", "w1"};

  lzc_counter #(.WIDTH(8), .MODE(0)) u_a (.clk_i(clk), .rst_ni(rst_ni), .in_i(in8), .cnt_o(cnt_a), .empty_o(emp_a));
  lzc_counter #(.WIDTH(8), .MODE(1)) u_b (.clk_i(clk), .rst_ni(rst_ni), .in_i(in8), .cnt_o(cnt_b), .empty_o(emp_b));
  lzc_counter #(.WIDTH(5), .MODE(0)) u_c (.clk_i(clk), .rst_ni(rst_ni), .in_i(in5), .cnt_o(cnt_c), .empty_o(emp_c));
  lzc_counter #(.WIDTH(5), .MODE(1)) u_d (.clk_i(clk), .rst_ni(rst_ni), .in_i(in5), .cnt_o(cnt_d), .empty_o(emp_d));
  lzc_counter #(.WIDTH(1), .MODE(0)) u_e (.clk_i(clk), .rst_ni(rst_ni), .in_i(in1), .cnt_o(cnt_e), .empty_o(emp_e));

  assign act_cnt[0] = 8'(cnt_a);
  assign act_cnt[1] = 8'(cnt_b);
  assign act_cnt[2] = 8'(cnt_c);
  assign act_cnt[3] = 8'(cnt_d);
  assign act_cnt[4] = 8'(cnt_e);
  assign act_emp    = {emp_e, emp_d, emp_c, emp_b, emp_a};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Zero count straight from the definition: distance from the scan start to the first one.
  function automatic void ref_lzc(input logic [7:0] v, input int w, input int mode,
                                  output int cnt, output bit empty);
    empty = 1'b1;
    cnt   = 0;
    for (int s = 0; s < w; s++) begin
      int pos;
      pos = (mode == 0) ? s : (w - 1 - s);
      if (empty && v[pos]) begin
        cnt   = s;
        empty = 1'b0;
      end
    end
  endfunction

  function automatic exp_t model(input logic [7:0] v8, input logic [4:0] v5, input logic v1);
    exp_t e;
    int   c;
    bit   m;
    e.cyc = cyc;
    ref_lzc(v8, 8, 0, c, m);          e.cnt[0] = 8'(c); e.emp[0] = m;
    ref_lzc(v8, 8, 1, c, m);          e.cnt[1] = 8'(c); e.emp[1] = m;
    ref_lzc({3'b0, v5}, 5, 0, c, m);  e.cnt[2] = 8'(c); e.emp[2] = m;
    ref_lzc({3'b0, v5}, 5, 1, c, m);  e.cnt[3] = 8'(c); e.emp[3] = m;
    ref_lzc({7'b0, v1}, 1, 0, c, m);  e.cnt[4] = 8'(c); e.emp[4] = m;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.cyc = cyc;
    e.cnt = '0;
    e.emp = '1;
    return e;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (act_cnt[d] !== e.cnt[d]) begin
        errors++;
        $display("FAIL %s %s cnt_o: got %0d expected %0d (in8=%h in5=%h in1=%b)",
                 tag, names[d], act_cnt[d], e.cnt[d], in8, in5, in1);
      end
      checks++;
      if (act_emp[d] !== e.emp[d]) begin
        errors++;
        $display("FAIL %s %s empty_o: got %b expected %b (in8=%h in5=%h in1=%b)",
                 tag, names[d], act_emp[d], e.emp[d], in8, in5, in1);
      end
    end
  endtask

  task automatic issue(input logic [7:0] v8, input logic [4:0] v5, input logic v1);
    in8 = v8;
    in5 = v5;
    in1 = v1;
    q.push_back(model(v8, v5, v1));
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc + LAT <= cyc) begin
      compare(q.pop_front(), "scoreboard");
    end
  end

  initial begin
    logic [7:0] dir8 [6];
    logic [7:0] r8;
    dir8 = '{8'h40, 8'h28, 8'h80, 8'h00, 8'h01, 8'hFF};

    rst_ni = 1'b1;
    in8    = 8'h40;
    in5    = 5'h10;
    in1    = 1'b1;
    #2 rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
`ifdef LZC_OUT_REG_EN
    compare(reset_exp(), "reset");
`else
    compare(model(in8, in5, in1), "reset");
`endif
    in8    = 8'h00;
    in5    = 5'h00;
    in1    = 1'b0;
    rst_ni = 1'b1;

    // Directed vectors plus exhaustive 5-bit sweep, then random traffic.
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      r8 = (k < 6) ? dir8[k] : 8'($urandom());
      issue(r8, 5'(k), 1'(k));
      if (k == 0) begin
`ifdef LZC_OUT_REG_EN
        @(negedge clk);
        compare(reset_exp(), "latency");
`endif
      end
    end
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      r8 = 8'($urandom());
      if ($urandom_range(1, 0) == 1) r8 = r8 & 8'($urandom()) & 8'($urandom());
      issue(r8, 5'($urandom()), 1'($urandom_range(1, 0)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
